// File: rtl/mem_io_responder.sv
// Byte-bus target for the CPU: byte RAM plus an I/O window holding the UART TX/RX
// FIFOs, a free-running cycle counter with a coherent read snapshot, and a halt flag.
module mem_io_responder #(
  parameter int    ADDR_WIDTH  = 17,
  parameter string INIT_FILE   = "",
  parameter int    TX_DEPTH    = 16,
  parameter int    RX_DEPTH    = 16,
  parameter int    FULL_MARGIN = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        halt,
  output logic        rx_overflow
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [TX_AW:0] TX_MARK_CNT = (TX_AW+1)'(TX_DEPTH - FULL_MARGIN);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);

  logic [7:0]        ram_r [0:(2**ADDR_WIDTH)-1];
  logic [7:0]        tx_mem_r [0:TX_DEPTH-1];
  logic [7:0]        rx_mem_r [0:RX_DEPTH-1];
  logic [TX_AW-1:0]  tx_wr_ptr_r, tx_rd_ptr_r;
  logic [TX_AW:0]    tx_count_r;
  logic [RX_AW-1:0]  rx_wr_ptr_r, rx_rd_ptr_r;
  logic [RX_AW:0]    rx_count_r;
  logic [31:0]       cycle_cnt_r;
  logic [31:0]       snap_r;
  logic [7:0]        mem_din_r;
  logic              halt_r;
  logic              rx_overflow_r;

  logic              is_ram_s, is_io_s, io_data_s, io_cnt_s, io_halt_s;
  logic              tx_full_s, tx_push_s, tx_pop_s;
  logic              rx_full_s, rx_empty_s, rx_push_s, rx_pop_s;
  logic [7:0]        rdata_s;
  logic              unused_addr_s;

  assign unused_addr_s = ^mem_a[31:18];

  // Address decode: only mem_a[17:0] is meaningful.
  always_comb begin
    is_ram_s  = (mem_a[17] == 1'b0);
    is_io_s   = (mem_a[17:16] == 2'b11);
    io_data_s = is_io_s && (mem_a[15:0] == 16'h0000);
    io_cnt_s  = is_io_s && (mem_a[15:2] == 14'h0001);
    io_halt_s = is_io_s && (mem_a[15:0] == 16'h0004);
  end

  // FIFO control; a push into a full FIFO is accepted only when a pop frees a slot.
  always_comb begin
    tx_full_s  = (tx_count_r == TX_FULL_CNT);
    tx_pop_s   = (tx_count_r != '0) && uart_tx_ready;
    tx_push_s  = mem_wr && io_data_s && (mem_dout != 8'h00) && (!tx_full_s || tx_pop_s);
    rx_full_s  = (rx_count_r == RX_FULL_CNT);
    rx_empty_s = (rx_count_r == '0);
    rx_pop_s   = !mem_wr && io_data_s && !rx_empty_s;
    rx_push_s  = uart_rx_valid && (!rx_full_s || rx_pop_s);
  end

  // Read data mux; byte0 of the counter comes live so it equals the snapshot being taken.
  always_comb begin
    rdata_s = 8'h00;
    if (mem_wr) begin
      rdata_s = 8'h00;
    end else if (is_ram_s) begin
      rdata_s = ram_r[mem_a[ADDR_WIDTH-1:0]];
    end else if (io_data_s) begin
      if (rx_empty_s) begin
        rdata_s = 8'h00;
      end else begin
        rdata_s = rx_mem_r[rx_rd_ptr_r];
      end
    end else if (io_cnt_s) begin
      case (mem_a[1:0])
        2'b00:   rdata_s = cycle_cnt_r[7:0];
        2'b01:   rdata_s = snap_r[15:8];
        2'b10:   rdata_s = snap_r[23:16];
        2'b11:   rdata_s = snap_r[31:24];
        default: rdata_s = 8'h00;
      endcase
    end else begin
      rdata_s = 8'h00;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_in) begin
    if (mem_wr && is_ram_s) begin
      ram_r[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
    end
  end

  // FIFO storage arrays.
  always_ff @(posedge clk_in) begin
    if (tx_push_s) begin
      tx_mem_r[tx_wr_ptr_r] <= mem_dout;
    end
    if (rx_push_s) begin
      rx_mem_r[rx_wr_ptr_r] <= uart_rx_data;
    end
  end

  // TX FIFO pointers and occupancy.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wr_ptr_r <= '0;
      tx_rd_ptr_r <= '0;
      tx_count_r  <= '0;
    end else begin
      if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + TX_AW'(1);
      if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + TX_AW'(1);
      case ({tx_push_s, tx_pop_s})
        2'b10:   tx_count_r <= tx_count_r + (TX_AW+1)'(1);
        2'b01:   tx_count_r <= tx_count_r - (TX_AW+1)'(1);
        default: tx_count_r <= tx_count_r;
      endcase
    end
  end

  // RX FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_wr_ptr_r   <= '0;
      rx_rd_ptr_r   <= '0;
      rx_count_r    <= '0;
      rx_overflow_r <= 1'b0;
    end else begin
      if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + RX_AW'(1);
      if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + RX_AW'(1);
      case ({rx_push_s, rx_pop_s})
        2'b10:   rx_count_r <= rx_count_r + (RX_AW+1)'(1);
        2'b01:   rx_count_r <= rx_count_r - (RX_AW+1)'(1);
        default: rx_count_r <= rx_count_r;
      endcase
      if (uart_rx_valid && !rx_push_s) rx_overflow_r <= 1'b1;
    end
  end

  // Cycle counter, read snapshot, halt flag and registered read data.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt_r <= 32'h0000_0000;
      snap_r      <= 32'h0000_0000;
      halt_r      <= 1'b0;
      mem_din_r   <= 8'h00;
    end else begin
      if (!halt_r) cycle_cnt_r <= cycle_cnt_r + 32'd1;
      if (!mem_wr && io_cnt_s && (mem_a[1:0] == 2'b00)) snap_r <= cycle_cnt_r;
      if (mem_wr && io_halt_s) halt_r <= 1'b1;
      mem_din_r <= rdata_s;
    end
  end

  assign mem_din        = mem_din_r;
  assign halt           = halt_r;
  assign rx_overflow    = rx_overflow_r;
  assign uart_tx_valid  = (tx_count_r != '0);
  assign uart_tx_data   = tx_mem_r[tx_rd_ptr_r];
  assign io_buffer_full = (tx_count_r >= TX_MARK_CNT);

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: expected read bytes and TX bytes are queued
// as stimulus is driven and compared when the DUT produces them.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        halt;
  logic        rx_overflow;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  din_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] m_cnt;
  logic        m_halt;
  logic [31:0] snap;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid), .halt(halt), .rx_overflow(rx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Reference cycle counter and halt flag.
  always @(posedge clk_in) begin
    if (rst_in) begin
      m_cnt  <= 32'h0;
      m_halt <= 1'b0;
    end else begin
      if (!m_halt) m_cnt <= m_cnt + 32'd1;
      if (mem_wr && mem_a[17:0] == 18'h30004) m_halt <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // TX consumer: every byte handed to the UART must be the next expected one.
  always @(negedge clk_in) begin
    if (!rst_in && uart_tx_valid && uart_tx_ready) begin
      if (tx_q.size() == 0) check("tx_unexpected", {31'h0, uart_tx_valid}, 32'h0);
      else check("tx_byte", {24'h0, uart_tx_data}, {24'h0, tx_q.pop_front()});
    end
  end

  task automatic xact(input logic wr, input logic [31:0] addr, input logic [7:0] data,
                      input logic [7:0] exp);
    mem_wr   = wr;
    mem_a    = addr;
    mem_dout = data;
    din_q.push_back(exp);
    @(posedge clk_in);
    #1;
    check("mem_din", {24'h0, mem_din}, {24'h0, din_q.pop_front()});
    mem_wr        = 1'b0;
    mem_a         = 32'h0002_0000;
    mem_dout      = 8'h00;
    uart_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) xact(1'b0, 32'h0002_0000, 8'h00, 8'h00);
  endtask

  task automatic rx_push(input logic [7:0] b);
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    xact(1'b0, 32'h0002_0000, 8'h00, 8'h00);
  endtask

  initial begin
    rst_in = 1'b1; mem_a = 32'h0002_0000; mem_dout = 8'h00; mem_wr = 1'b0;
    uart_tx_ready = 1'b0; uart_rx_data = 8'h00; uart_rx_valid = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check("rst_din", {24'h0, mem_din}, 32'h0);
    check("rst_halt", {31'h0, halt}, 32'h0);
    check("rst_ovf", {31'h0, rx_overflow}, 32'h0);
    check("rst_txv", {31'h0, uart_tx_valid}, 32'h0);
    check("rst_full", {31'h0, io_buffer_full}, 32'h0);

    // RAM write then read-after-write at several addresses
    xact(1'b1, 32'h0000_0010, 8'hA5, 8'h00);
    xact(1'b0, 32'h0000_0010, 8'h00, 8'hA5);
    xact(1'b1, 32'h0001_FFFF, 8'h3C, 8'h00);
    xact(1'b1, 32'h0000_FFFF, 8'hC3, 8'h00);
    xact(1'b0, 32'h0001_FFFF, 8'h00, 8'h3C);
    xact(1'b0, 32'h0000_FFFF, 8'h00, 8'hC3);
    // unmapped window: write ignored, read zero, RAM alias untouched
    xact(1'b1, 32'h0002_0010, 8'h77, 8'h00);
    xact(1'b0, 32'h0002_0010, 8'h00, 8'h00);
    xact(1'b0, 32'h0000_0010, 8'h00, 8'hA5);

    // TX streaming with zero byte filtered
    uart_tx_ready = 1'b1;
    tx_q.push_back(8'h41); xact(1'b1, 32'h0003_0000, 8'h41, 8'h00);
    xact(1'b1, 32'h0003_0000, 8'h00, 8'h00);
    tx_q.push_back(8'h42); xact(1'b1, 32'h0003_0000, 8'h42, 8'h00);
    idle(3);
    check("tx2_left", tx_q.size(), 32'h0);
    check("tx2_valid", {31'h0, uart_tx_valid}, 32'h0);

    // TX fill: near-full threshold, full drop, in-order drain
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) tx_q.push_back(8'h50 + 8'(i));
      xact(1'b1, 32'h0003_0000, 8'h50 + 8'(i), 8'h00);
      if (i == 10) check("full_11", {31'h0, io_buffer_full}, 32'h0);
      if (i == 11) check("full_12", {31'h0, io_buffer_full}, 32'h1);
    end
    check("full_17", {31'h0, io_buffer_full}, 32'h1);
    uart_tx_ready = 1'b1;
    idle(20);
    check("tx3_left", tx_q.size(), 32'h0);
    check("tx3_valid", {31'h0, uart_tx_valid}, 32'h0);
    check("tx3_full", {31'h0, io_buffer_full}, 32'h0);

    // RX pops, empty read, overflow
    rx_push(8'h31);
    rx_push(8'h32);
    xact(1'b0, 32'h0003_0000, 8'h00, 8'h31);
    xact(1'b0, 32'h0003_0000, 8'h00, 8'h32);
    xact(1'b0, 32'h0003_0000, 8'h00, 8'h00);
    for (int i = 0; i < 17; i++) begin
      rx_push(8'h60 + 8'(i));
      if (i == 15) check("ovf_16", {31'h0, rx_overflow}, 32'h0);
    end
    check("ovf_17", {31'h0, rx_overflow}, 32'h1);
    for (int i = 0; i < 16; i++) xact(1'b0, 32'h0003_0000, 8'h00, 8'h60 + 8'(i));
    xact(1'b0, 32'h0003_0000, 8'h00, 8'h00);

    // counter snapshot across a byte-0 carry
    for (int i = 0; i < 600 && m_cnt[7:0] != 8'hFD; i++) idle(1);
    check("cnt_reach", {24'h0, m_cnt[7:0]}, 32'hFD);
    snap = m_cnt;
    xact(1'b0, 32'h0003_0004, 8'h00, snap[7:0]);
    xact(1'b0, 32'h0003_0005, 8'h00, snap[15:8]);
    xact(1'b0, 32'h0003_0006, 8'h00, snap[23:16]);
    xact(1'b0, 32'h0003_0007, 8'h00, snap[31:24]);
    xact(1'b0, 32'h0003_0008, 8'h00, 8'h00);
    // halt freezes the counter
    xact(1'b1, 32'h0003_0004, 8'h00, 8'h00);
    check("halt_set", {31'h0, halt}, 32'h1);
    snap = m_cnt;
    xact(1'b0, 32'h0003_0004, 8'h00, snap[7:0]);
    idle(5);
    xact(1'b0, 32'h0003_0004, 8'h00, snap[7:0]);
    xact(1'b0, 32'h0003_0005, 8'h00, snap[15:8]);

    // reset with queued TX/RX traffic
    uart_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) xact(1'b1, 32'h0003_0000, 8'h90 + 8'(i), 8'h00);
    rx_push(8'h99);
    check("pre_rst_txv", {31'h0, uart_tx_valid}, 32'h1);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check("rst2_txv", {31'h0, uart_tx_valid}, 32'h0);
    check("rst2_halt", {31'h0, halt}, 32'h0);
    check("rst2_din", {24'h0, mem_din}, 32'h0);
    check("rst2_full", {31'h0, io_buffer_full}, 32'h0);
    xact(1'b0, 32'h0003_0004, 8'h00, 8'h00);
    xact(1'b0, 32'h0003_0005, 8'h00, 8'h00);
    xact(1'b0, 32'h0003_0000, 8'h00, 8'h00);
    uart_tx_ready = 1'b1;
    idle(4);
    xact(1'b0, 32'h0000_0010, 8'h00, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
